exec_mem_unit_mc: RTL

Parametrised multi-cycle successor to the single-cycle arithmetic/memory datapath. It accepts one 32-bit instruction word plus control bits over a valid/ready handshake and reads two operands from an internal 32-entry register file. It executes on an 8-op ALU, optionally accesses an internal data memory with configurable wait states, and writes back, pulsing `done`. It sits between the control FSM/PC logic and the rest of the core.

---
 rtl/exec_mem_unit_mc_if.sv | 33 +++
 rtl/exec_mem_unit_mc.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit_mc_if.sv
// rtl/exec_mem_unit_mc_if.sv - issue/retire bundle between control logic and exec_mem_unit_mc
interface exec_mem_unit_mc_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] pc_in;
   logic [2:0]        alu_op;
   logic [1:0]        alu_in_sel;
   logic              reg_write;
   logic              mem_read;
   logic              mem_write;
   logic              mem_to_reg;
   logic              data_pc_sel;
   logic              reg_select;
   logic              done;
   logic [DATA_W-1:0] output_data;
   logic [DATA_W-1:0] alu_result;
   logic [2:0]        flags;

   modport master (
      output in_valid, instr, pc_in, alu_op, alu_in_sel,
             reg_write, mem_read, mem_write, mem_to_reg, data_pc_sel, reg_select,
      input  in_ready, done, output_data, alu_result, flags
   );

   modport slave (
      input  in_valid, instr, pc_in, alu_op, alu_in_sel,
             reg_write, mem_read, mem_write, mem_to_reg, data_pc_sel, reg_select,
      output in_ready, done, output_data, alu_result, flags
   );
endinterface

// File: rtl/exec_mem_unit_mc.sv
// rtl/exec_mem_unit_mc.sv - multi-cycle execute/memory/writeback datapath
// IDLE -> EXEC -> [MEM x MEM_LAT] -> WB, one instruction in flight at a time.
module exec_mem_unit_mc #(
   parameter int DATA_W     = 32,
   parameter int DMEM_DEPTH = 256,
   parameter int MEM_LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   exec_mem_unit_mc_if.slave bus
);
   localparam int SH_W  = $clog2(DATA_W);
   localparam int AW    = $clog2(DMEM_DEPTH);
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MEM  = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        ra_q, rb_q;
   logic [15:0]       imm_q;
   logic [DATA_W-1:0] pc_q;
   logic [2:0]        op_q;
   logic [1:0]        sel_q;
   logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, data_pc_sel_q, reg_select_q;
   logic [DATA_W-1:0] rf_q [32];
   logic [DATA_W-1:0] alu_q, store_q, load_q, out_q;
   logic [2:0]        flags_q;
   logic              done_q;
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];

   logic              accept;
   logic              last_mem;
   logic [DATA_W-1:0] op_a, rb_val, op_b, res, wb_data;
   logic [DATA_W:0]   sum_ext;
   logic              carry;
   logic [SH_W-1:0]   shamt;
   logic [4:0]        dest;
   logic [AW-1:0]     addr;
   logic              unused_ok;

   assign accept   = bus.in_valid && (state_q == S_IDLE);
   assign last_mem = (state_q == S_MEM) && (cnt_q == CNT_W'(1));
   assign op_a     = (ra_q == 5'd0) ? '0 : rf_q[ra_q];
   assign rb_val   = (rb_q == 5'd0) ? '0 : rf_q[rb_q];
   assign shamt    = op_b[SH_W-1:0];
   assign addr     = alu_q[AW-1:0];
   assign dest     = reg_select_q ? 5'd31 : rb_q;
   assign wb_data  = data_pc_sel_q ? (pc_q + DATA_W'(1)) : (mem_to_reg_q ? alu_q : load_q);

   // Address wraps by dropping upper ALU bits; opcode bits above rb are not used here.
   assign unused_ok = &{1'b0, alu_q[DATA_W-1:AW], bus.instr[31:26]};

   always_comb begin
      case (sel_q)
         2'd0:    op_b = rb_val;
         2'd1:    op_b = '0;
         2'd2:    op_b = DATA_W'(imm_q);
         default: op_b = DATA_W'(1);
      endcase
   end

   always_comb begin
      sum_ext = {1'b0, op_a} + {1'b0, op_b};
      res     = '0;
      carry   = 1'b0;
      case (op_q)
         3'd0: begin
            res   = sum_ext[DATA_W-1:0];
            carry = sum_ext[DATA_W];
         end
         3'd1: begin
            res   = op_a - op_b;
            carry = (op_a < op_b);
         end
         3'd2:    res = op_a & op_b;
         3'd3:    res = op_a | op_b;
         3'd4:    res = op_a ^ op_b;
         3'd5:    res = op_a << shamt;
         3'd6:    res = op_a >> shamt;
         default: res = $unsigned($signed(op_a) >>> shamt);
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) state_d = S_EXEC;
         S_EXEC: begin
            if (mem_read_q || mem_write_q) begin
               state_d = S_MEM;
               cnt_d   = CNT_W'(MEM_LAT);
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (last_mem) state_d = S_WB;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         ra_q          <= '0;
         rb_q          <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         op_q          <= '0;
         sel_q         <= '0;
         reg_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         data_pc_sel_q <= 1'b0;
         reg_select_q  <= 1'b0;
         alu_q         <= '0;
         store_q       <= '0;
         load_q        <= '0;
         out_q         <= '0;
         flags_q       <= '0;
         done_q        <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_q == S_WB);
         if (accept) begin
            ra_q          <= bus.instr[20:16];
            rb_q          <= bus.instr[25:21];
            imm_q         <= bus.instr[15:0];
            pc_q          <= bus.pc_in;
            op_q          <= bus.alu_op;
            sel_q         <= bus.alu_in_sel;
            reg_write_q   <= bus.reg_write;
            mem_read_q    <= bus.mem_read;
            mem_write_q   <= bus.mem_write;
            mem_to_reg_q  <= bus.mem_to_reg;
            data_pc_sel_q <= bus.data_pc_sel;
            reg_select_q  <= bus.reg_select;
         end
         if (state_q == S_EXEC) begin
            alu_q   <= res;
            flags_q <= {carry, (res == '0), res[DATA_W-1]};
            store_q <= rb_val;
         end
         if (last_mem && mem_read_q && !mem_write_q) load_q <= dmem[addr];
         if (state_q == S_WB) begin
            out_q <= wb_data;
            if (reg_write_q && (dest != 5'd0)) rf_q[dest] <= wb_data;
         end
      end
   end

   // Data memory has no reset; an aborted store never reaches last_mem because state clears async.
   always_ff @(posedge clk) begin
      if (last_mem && mem_write_q) dmem[addr] <= store_q;
   end

   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.done        = done_q;
   assign bus.output_data = out_q;
   assign bus.alu_result  = alu_q;
   assign bus.flags       = flags_q;
endmodule
